// File: rtl/float_type.sv
// float_type: shared FP32 result types for the multiplier capture path.
//   type_of_float : classification of an FP32 bit pattern
//   fq_entry_t    : one queued result {result, flags {N,O,U}, class}
//   FQ_U/FQ_O/FQ_N: bit positions of the flags inside fq_entry_t.flags
package float_type;

  typedef enum logic [2:0] {
    ZERO              = 3'd0,
    denormalized      = 3'd1,
    normalized        = 3'd2,
    positive_infinity = 3'd3,
    negative_infinity = 3'd4,
    NaN               = 3'd5
  } type_of_float;

  typedef struct packed {
    logic [31:0]  result;
    logic [2:0]   flags;
    type_of_float cls;
  } fq_entry_t;

  localparam int unsigned FQ_U = 0;
  localparam int unsigned FQ_O = 1;
  localparam int unsigned FQ_N = 2;

endpackage

// File: rtl/fp_classify.sv
// fp_classify: purely combinational FP32 bit-pattern classifier.
//   fp_in  : 32-bit IEEE-754 single-precision pattern
//   fp_cls : resulting type_of_float
module fp_classify
  import float_type::*;
(
  input  logic [31:0]  fp_in,
  output type_of_float fp_cls
);

  logic        sign_w;
  logic [7:0]  exp_w;
  logic [22:0] mant_w;

  assign sign_w = fp_in[31];
  assign exp_w  = fp_in[30:23];
  assign mant_w = fp_in[22:0];

  always_comb begin
    fp_cls = normalized;
    if (exp_w == 8'h00) begin
      fp_cls = (mant_w == '0) ? ZERO : denormalized;
    end else if (exp_w == 8'hFF) begin
      if (mant_w != '0) begin
        fp_cls = NaN;
      end else begin
        fp_cls = sign_w ? negative_infinity : positive_infinity;
      end
    end
  end

endmodule

// File: rtl/fp_result_queue.sv
// fp_result_queue: capture FIFO behind the FP32 multiplier.
//   in_valid/in_ready/in_result/in_u/in_o/in_n : upstream handshake + data
//   out_valid/out_ready/out_result/out_flags/out_class : head of queue
//     (head data reads as zero / ZERO while the queue is empty)
//   level      : occupancy, 0..DEPTH
//   clr_sticky : clears sticky flags (a same-cycle flagged accept wins)
//   sticky_*   : sticky exception flags
//   *_cnt      : saturating per-flag event counters
module fp_result_queue
  import float_type::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  input  logic                     in_u,
  input  logic                     in_o,
  input  logic                     in_n,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [2:0]               out_flags,
  output type_of_float             out_class,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     clr_sticky,
  output logic                     sticky_u,
  output logic                     sticky_o,
  output logic                     sticky_n,
  output logic [CNT_W-1:0]         unf_cnt,
  output logic [CNT_W-1:0]         ovf_cnt,
  output logic [CNT_W-1:0]         nan_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  fq_entry_t           mem_q [DEPTH];
  fq_entry_t           mem_d [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic [2:0]          sticky_q, sticky_d;
  logic [CNT_W-1:0]    unf_cnt_q, unf_cnt_d;
  logic [CNT_W-1:0]    ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0]    nan_cnt_q, nan_cnt_d;

  logic                accept;
  logic                pop;
  logic [2:0]          in_flags;
  type_of_float        in_cls;
  fq_entry_t           wr_entry;
  fq_entry_t           head;

  fp_classify u_classify (
    .fp_in  (in_result),
    .fp_cls (in_cls)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic en);
    return (en && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  assign in_flags = {in_n, in_o, in_u};
  assign wr_entry = '{result: in_result, flags: in_flags, cls: in_cls};

  assign in_ready  = (level_q < DEPTH_L);
  assign out_valid = (level_q != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // The head slot is never overwritten while occupied (no push when full),
  // so a direct read of mem_q[rd_ptr_q] is stable until the next pop.
  assign head       = mem_q[rd_ptr_q];
  assign out_result = out_valid ? head.result : '0;
  assign out_flags  = out_valid ? head.flags  : '0;
  assign out_class  = out_valid ? head.cls    : ZERO;
  assign level      = level_q;

  assign sticky_u = sticky_q[FQ_U];
  assign sticky_o = sticky_q[FQ_O];
  assign sticky_n = sticky_q[FQ_N];
  assign unf_cnt  = unf_cnt_q;
  assign ovf_cnt  = ovf_cnt_q;
  assign nan_cnt  = nan_cnt_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (accept) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    unique case ({accept, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // Clear first, then OR in new flags so a same-cycle set wins.
    sticky_d = (clr_sticky ? 3'b000 : sticky_q) | (accept ? in_flags : 3'b000);

    unf_cnt_d = sat_inc(unf_cnt_q, accept && in_u);
    ovf_cnt_d = sat_inc(ovf_cnt_q, accept && in_o);
    nan_cnt_d = sat_inc(nan_cnt_q, accept && in_n);
  end

  // Storage carries no reset; entries are only observable behind level_q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= mem_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      sticky_q  <= '0;
      unf_cnt_q <= '0;
      ovf_cnt_q <= '0;
      nan_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      sticky_q  <= sticky_d;
      unf_cnt_q <= unf_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
      nan_cnt_q <= nan_cnt_d;
    end
  end

endmodule

// File: tb/tb_fp_result_queue.sv
// tb_fp_result_queue: directed + randomized bench for fp_result_queue.
// Two instances share stimulus: a default one (CNT_W=16) and one with
// CNT_W=2 to exercise counter saturation.
module tb_fp_result_queue;
  import float_type::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready, clr_sticky;
  logic in_u, in_o, in_n;
  logic [31:0] in_result;

  logic         a_in_ready, a_out_valid, a_su, a_so, a_sn;
  logic [31:0]  a_out_result;
  logic [2:0]   a_out_flags;
  type_of_float a_out_class;
  logic [2:0]   a_level;
  logic [15:0]  a_unf, a_ovf, a_nan;

  logic         s_in_ready, s_out_valid, s_su, s_so, s_sn;
  logic [31:0]  s_out_result;
  logic [2:0]   s_out_flags;
  type_of_float s_out_class;
  logic [2:0]   s_level;
  logic [1:0]   s_unf, s_ovf, s_nan;

  type_of_float ref_cls;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] r;
    logic [2:0]  f;
  } item_t;

  item_t       mq[$];
  logic [2:0]  m_sticky;
  int          m_cnt[3];
  bit          last_acc;

  always #5 clk = ~clk;

  fp_result_queue #(.DEPTH(DEPTH), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_result(in_result), .in_u(in_u), .in_o(in_o), .in_n(in_n),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_result(a_out_result),
    .out_flags(a_out_flags), .out_class(a_out_class), .level(a_level),
    .clr_sticky(clr_sticky), .sticky_u(a_su), .sticky_o(a_so), .sticky_n(a_sn),
    .unf_cnt(a_unf), .ovf_cnt(a_ovf), .nan_cnt(a_nan)
  );

  fp_result_queue #(.DEPTH(DEPTH), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_result(in_result), .in_u(in_u), .in_o(in_o), .in_n(in_n),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_result(s_out_result),
    .out_flags(s_out_flags), .out_class(s_out_class), .level(s_level),
    .clr_sticky(clr_sticky), .sticky_u(s_su), .sticky_o(s_so), .sticky_n(s_sn),
    .unf_cnt(s_unf), .ovf_cnt(s_ovf), .nan_cnt(s_nan)
  );

  fp_classify u_ref_cls (.fp_in(in_result), .fp_cls(ref_cls));

  // Classification straight from the IEEE-754 field rules.
  function automatic type_of_float classify(input logic [31:0] r);
    int unsigned e, m;
    e = (r >> 23) & 32'hFF;
    m = r & 32'h7FFFFF;
    if (e == 0) return (m == 0) ? ZERO : denormalized;
    if (e == 255) begin
      if (m != 0) return NaN;
      return r[31] ? negative_infinity : positive_infinity;
    end
    return normalized;
  endfunction

  function automatic int unsigned sat(input int v, input int unsigned maxv);
    return (v > int'(maxv)) ? maxv : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] er;
    logic [2:0]  ef;
    type_of_float ec;
    bit ev;
    ev = (mq.size() != 0);
    er = ev ? mq[0].r : 32'h0;
    ef = ev ? mq[0].f : 3'b000;
    ec = ev ? classify(mq[0].r) : ZERO;
    chk("level",      32'(a_level),       32'(mq.size()));
    chk("out_valid",  32'(a_out_valid),   32'(ev));
    chk("in_ready",   32'(a_in_ready),    32'(mq.size() < DEPTH));
    chk("out_result", a_out_result,       er);
    chk("out_flags",  32'(a_out_flags),   32'(ef));
    chk("out_class",  32'(a_out_class),   32'(ec));
    chk("sticky",     32'({a_sn, a_so, a_su}), 32'(m_sticky));
    chk("unf_cnt",    32'(a_unf),         sat(m_cnt[FQ_U], 65535));
    chk("ovf_cnt",    32'(a_ovf),         sat(m_cnt[FQ_O], 65535));
    chk("nan_cnt",    32'(a_nan),         sat(m_cnt[FQ_N], 65535));
    chk("s_level",    32'(s_level),       32'(mq.size()));
    chk("s_result",   s_out_result,       er);
    chk("s_unf_cnt",  32'(s_unf),         sat(m_cnt[FQ_U], 3));
    chk("s_ovf_cnt",  32'(s_ovf),         sat(m_cnt[FQ_O], 3));
    chk("s_nan_cnt",  32'(s_nan),         sat(m_cnt[FQ_N], 3));
  endtask

  // One clock: update the reference model from the inputs held across the
  // edge, then compare everything 1 time unit later.
  task automatic cycle();
    bit acc, pp;
    logic [2:0] fl;
    @(posedge clk);
    fl = {in_n, in_o, in_u};
    acc = 1'b0;
    if (rst) begin
      mq.delete();
      m_sticky = 3'b000;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else begin
      acc = in_valid && (mq.size() < DEPTH);
      pp  = (mq.size() != 0) && out_ready;
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back('{r: in_result, f: fl});
      m_sticky = (clr_sticky ? 3'b000 : m_sticky) | (acc ? fl : 3'b000);
      if (acc) for (int i = 0; i < 3; i++) if (fl[i]) m_cnt[i]++;
    end
    last_acc = acc;
    #1;
    check_all();
    chk("ref_classify", 32'(ref_cls), 32'(classify(in_result)));
  endtask

  task automatic drive(input bit v, input logic [31:0] r, input logic [2:0] f,
                       input bit ordy, input bit clr);
    in_valid = v; in_result = r; {in_n, in_o, in_u} = f;
    out_ready = ordy; clr_sticky = clr;
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: r[30:23] = 8'h00;
      1: r[30:23] = 8'hFF;
      default: ;
    endcase
    if ($urandom_range(0, 2) == 0) r[22:0] = '0;
    return r;
  endfunction

  initial begin
    logic [31:0] specials [4];
    type_of_float spec_cls [4];
    specials = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h00000001};
    spec_cls = '{positive_infinity, negative_infinity, NaN, denormalized};
    m_sticky = 3'b000;
    foreach (m_cnt[i]) m_cnt[i] = 0;
    last_acc = 1'b0;

    // Reset
    rst = 1'b1;
    drive(0, 32'h0, 3'b000, 0, 0);
    cycle(); cycle();
    rst = 1'b0;
    chk("rst_class", 32'(a_out_class), 32'(ZERO));

    // First push: visible one cycle later
    drive(1, 32'h3F800000, 3'b000, 0, 0);
    cycle();
    chk("first_valid", 32'(a_out_valid), 32'd1);
    chk("first_class", 32'(a_out_class), 32'(normalized));
    drive(0, 32'h0, 3'b000, 1, 0);
    cycle();

    // Fill with special values, then try a fifth push
    for (int k = 0; k < 4; k++) begin
      drive(1, specials[k], 3'b000, 0, 0);
      cycle();
    end
    chk("full_ready", 32'(a_in_ready), 32'd0);
    drive(1, 32'h40490FDB, 3'b000, 0, 0);
    cycle(); cycle();
    chk("full_level", 32'(a_level), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("special_class", 32'(a_out_class), 32'(spec_cls[k]));
      out_ready = 1'b1;
      cycle();
      if (last_acc) in_valid = 1'b0;
    end
    drive(0, 32'h0, 3'b000, 1, 0);
    while (mq.size() != 0) cycle();

    // Level 2, simultaneous push+pop across pointer wrap
    drive(1, 32'h11111111, 3'b000, 0, 0); cycle();
    drive(1, 32'h22222222, 3'b000, 0, 0); cycle();
    for (int k = 0; k < 10; k++) begin
      drive(1, rand_fp(), 3'($urandom), 1, 0);
      cycle();
      chk("pushpop_level", 32'(a_level), 32'd2);
    end
    drive(0, 32'h0, 3'b000, 1, 0);
    cycle(); cycle();

    // Sticky set beats same-cycle clear
    drive(0, 32'h0, 3'b000, 1, 1); cycle();
    drive(1, 32'h7F800000, 3'b010, 1, 1); cycle();
    chk("sticky_set_wins", 32'(a_so), 32'd1);
    drive(0, 32'h0, 3'b000, 1, 1); cycle();
    chk("sticky_cleared", 32'(a_so), 32'd0);

    // Counter saturation after a clean reset
    rst = 1'b1; drive(0, 32'h0, 3'b000, 0, 0); cycle(); rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1, 32'h7FC00001, 3'b100, 1, 0);
      cycle();
    end
    drive(0, 32'h0, 3'b000, 1, 0); cycle(); cycle();
    chk("sat_nan", 32'(s_nan), 32'd3);
    chk("sat_unf", 32'(s_unf), 32'd0);
    chk("sat_ovf", 32'(s_ovf), 32'd0);
    chk("wide_nan", 32'(a_nan), 32'd5);

    // Randomized traffic; upstream holds data until accepted
    drive(0, 32'h0, 3'b000, 0, 0);
    last_acc = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (!in_valid || last_acc) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_result = rand_fp();
        {in_n, in_o, in_u} = 3'($urandom);
      end
      out_ready  = ($urandom_range(0, 2) != 0);
      clr_sticky = ($urandom_range(0, 9) == 0);
      cycle();
    end

    // Reset mid-operation with level 3 and a simultaneous push
    drive(0, 32'h0, 3'b000, 1, 0);
    while (mq.size() != 0) cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1, rand_fp(), 3'b111, 0, 0);
      cycle();
    end
    chk("pre_rst_level", 32'(a_level), 32'd3);
    rst = 1'b1;
    drive(1, 32'h3F800000, 3'b111, 1, 0);
    cycle();
    rst = 1'b0;
    drive(0, 32'h0, 3'b000, 0, 0);
    chk("rst_level", 32'(a_level), 32'd0);
    chk("rst_valid", 32'(a_out_valid), 32'd0);
    chk("rst_cls", 32'(a_out_class), 32'(ZERO));
    chk("rst_sticky", 32'({a_sn, a_so, a_su}), 32'd0);
    chk("rst_cnts", 32'({a_nan, a_ovf}) | 32'(a_unf), 32'd0);
    cycle();
    chk("rst_ready", 32'(a_in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
